demux1: RTL and testbench
=========================

DEMUX1 -- requirements
Module: demux1

Interface
REQ-001 The block SHALL have parameter N, default 4, the number of output lanes and of select lines.
REQ-002 Port clk SHALL be an input, 1 bit wide: the single system clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: the reset, asynchronous and active-low.
REQ-004 Port serIn SHALL be an input, 1 bit wide: the serial data bit to be distributed.
REQ-005 Port PB SHALL be an input, N bits wide (PB[0]..PB[N-1]): one enable (push-button) line per output lane; lanes are independent, not encoded.
REQ-006 Port P SHALL be an output, N bits wide (P[0]..P[N-1]): the demultiplexed data lanes, driven directly from registers.

Function
REQ-007 On each rising clk edge with rst_n high, for every i in 0..N-1, P[i] SHALL load (serIn AND PB[i]).
REQ-008 A lane whose PB[i] is 0 SHALL output 0 on the following cycle; it SHALL NOT hold its previous value.
REQ-009 Any number of PB bits MAY be high simultaneously; every enabled lane SHALL receive the same serIn value in the same cycle (broadcast).
REQ-010 PB all-zero SHALL drive P to all-zero regardless of serIn.
REQ-011 serIn = 0 SHALL drive P to all-zero regardless of PB.
REQ-012 Latency from serIn or PB to P SHALL be exactly one clk cycle; there SHALL be no combinational path from any input to P.
REQ-013 Lanes SHALL be independent: a change on PB[j] SHALL NOT affect P[i] for i != j.
REQ-014 serIn and PB SHALL be treated as synchronous to clk; synchronisation of raw button inputs is the integrator's responsibility.
REQ-015 The block SHALL contain no other state than the N output registers; no handshake, no FSM.
REQ-016 The implementation SHALL be valid for any N >= 1.

Reset
REQ-017 While rst_n is low, P SHALL be all-zero, asynchronously, without waiting for a clk edge.
REQ-018 Assertion of rst_n mid-operation SHALL clear P immediately, regardless of serIn and PB.
REQ-019 After rst_n deasserts, the first rising clk edge SHALL apply REQ-007 normally.
REQ-020 Deassertion of rst_n SHALL be synchronised externally to clk; the block needs no reset synchroniser.

Verification
REQ-021 The bench SHALL run scenario 1: reset asserted, serIn=1, PB=4'b1111 -> P=4'b0000 with no clock edge; reset released, next edge -> P=4'b1111.
REQ-022 The bench SHALL run scenario 2: serIn=1, PB swept 4'b0000..4'b1111, one value per cycle -> P equals the previous cycle's PB on every cycle, including P=4'b0000 for PB=4'b0000.
REQ-023 The bench SHALL run scenario 3: serIn=0, PB=4'b1111 -> P=4'b0000 on the next edge.
REQ-024 The bench SHALL run scenario 4: PB=4'b0101, serIn toggling 1,0,1 over three cycles -> P=4'b0101, 4'b0000, 4'b0101 with one-cycle lag.
REQ-025 The bench SHALL run scenario 5: PB changes from 4'b0001 to 4'b1000 with serIn=1 -> P goes from 4'b0001 to 4'b1000 one cycle later; lane 0 clears without holding.
REQ-026 The bench SHALL run scenario 6: rst_n pulsed low between clock edges while P=4'b1111 -> P=4'b0000 immediately and stays 0 until the first edge after release.

Source files
------------

// File: rtl/demux1.sv
// demux1: broadcasts a serial bit onto N independently enabled lanes.
// Each lane is a single register that loads serIn AND its own enable line.
module demux1 #(
    parameter int unsigned N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         serIn,
    input  logic [N-1:0] PB,
    output logic [N-1:0] P
);

    logic [N-1:0] r_p;
    logic [N-1:0] w_p_d;

    // Disabled lanes load 0 rather than holding, so a plain AND is the whole next-state.
    always_comb begin
        w_p_d = PB & {N{serIn}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p <= '0;
        end else begin
            r_p <= w_p_d;
        end
    end

    assign P = r_p;

endmodule

// File: tb/tb_demux1.sv
// Directed, scoreboard-based bench for demux1 (N = 4).
// Expected lane values are queued when stimulus is driven and checked one edge later.
module tb_demux1;

    logic       clk;
    logic       rst_n;
    logic       serIn;
    logic [3:0] PB;
    logic [3:0] P;

    int unsigned vectors;
    int unsigned miscompares;
    logic [3:0]  sb[$];

    demux1 #(.N(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .serIn(serIn),
        .PB   (PB),
        .P    (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, record the expected result, compare after the edge.
    task automatic step(input string tag, input logic s, input logic [3:0] pb);
        logic [3:0] exp;
        @(negedge clk);
        serIn = s;
        PB    = pb;
        sb.push_back(pb & {4{s}});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            exp = sb.pop_front();
            check(tag, P, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Scenario 1: reset clears P asynchronously, release gives 1111 on next edge.
        rst_n = 1'b0;
        serIn = 1'b1;
        PB    = 4'b1111;
        #2;
        check("reset_async", P, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release_no_edge", P, 4'b0000);
        sb.push_back(4'b1111);
        @(posedge clk);
        #1;
        check("first_edge_after_reset", P, sb.pop_front());

        // Scenario 2: sweep PB with serIn = 1.
        for (int v = 0; v < 16; v++) begin
            step("pb_sweep", 1'b1, v[3:0]);
        end

        // Scenario 3: serIn = 0 gates every lane.
        step("serin_zero_prime", 1'b1, 4'b1111);
        step("serin_zero", 1'b0, 4'b1111);

        // Scenario 4: serIn toggling on a fixed enable pattern.
        step("toggle_1", 1'b1, 4'b0101);
        step("toggle_0", 1'b0, 4'b0101);
        step("toggle_1b", 1'b1, 4'b0101);

        // Scenario 5: lane 0 clears when its enable drops.
        step("lane_move_a", 1'b1, 4'b0001);
        step("lane_move_b", 1'b1, 4'b1000);

        // Scenario 6: mid-cycle reset pulse while P = 1111.
        step("pre_pulse", 1'b1, 4'b1111);
        #2;
        rst_n = 1'b0;
        #1;
        check("pulse_async_clear", P, 4'b0000);
        @(posedge clk);
        #1;
        check("pulse_held_over_edge", P, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("pulse_release_no_edge", P, 4'b0000);
        sb.push_back(4'b1111);
        @(posedge clk);
        #1;
        check("pulse_first_edge", P, sb.pop_front());

        // A few random cycles for broadcast and lane independence.
        for (int k = 0; k < 12; k++) begin
            step("random", 1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
